// File: rtl/legv8_control_unit.sv
// rtl/legv8_control_unit.sv - multi-cycle LEGv8 control sequencer
// Owns PC and IR, fetches via a valid handshake, drives the datapath control word.
module legv8_control_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [4:0]  ZR       = 5'd31
) (
  input  logic        clock,
  input  logic        reset,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic [63:0] pc,
  input  logic [3:0]  status,
  output logic [24:0] control_word,
  output logic [63:0] constant,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01011;
  localparam logic [24:0] NOP_WORD = {ZR, 20'b0};

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        halted_q, halted_d;

  logic [4:0]  rd, rn, rm;
  logic [63:0] imm12_ext, imm9_ext, br26_off, br19_off;
  logic        is_add, is_sub, is_and, is_orr, is_eor;
  logic        is_addi, is_subi, is_andi, is_orri;
  logic        is_ldur, is_stur, is_b, is_cbz, is_cbnz;
  logic        is_rtype, is_itype, is_known, cb_taken;
  logic [63:0] pc_exec;
  logic        unused_status;

  assign rd = ir_q[4:0];
  assign rn = ir_q[9:5];
  assign rm = ir_q[20:16];

  assign imm12_ext = {52'b0, ir_q[21:10]};
  assign imm9_ext  = {{55{ir_q[20]}}, ir_q[20:12]};
  assign br26_off  = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
  assign br19_off  = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};

  assign is_add  = (ir_q[31:21] == 11'b10001011000);
  assign is_sub  = (ir_q[31:21] == 11'b11001011000);
  assign is_and  = (ir_q[31:21] == 11'b10001010000);
  assign is_orr  = (ir_q[31:21] == 11'b10101010000);
  assign is_eor  = (ir_q[31:21] == 11'b11001010000);
  assign is_addi = (ir_q[31:22] == 10'b1001000100);
  assign is_subi = (ir_q[31:22] == 10'b1101000100);
  assign is_andi = (ir_q[31:22] == 10'b1001001000);
  assign is_orri = (ir_q[31:22] == 10'b1011001000);
  assign is_ldur = (ir_q[31:21] == 11'b11111000010);
  assign is_stur = (ir_q[31:21] == 11'b11111000000);
  assign is_b    = (ir_q[31:26] == 6'b000101);
  assign is_cbz  = (ir_q[31:24] == 8'b10110100);
  assign is_cbnz = (ir_q[31:24] == 8'b10110101);

  assign is_rtype = is_add | is_sub | is_and | is_orr | is_eor;
  assign is_itype = is_addi | is_subi | is_andi | is_orri;
  assign is_known = is_rtype | is_itype | is_ldur | is_stur | is_b | is_cbz | is_cbnz;

  // Only Z steers branches; the other flags are observed by the datapath alone.
  assign cb_taken      = (is_cbz & status[0]) | (is_cbnz & ~status[0]);
  assign unused_status = ^status[3:1];

  assign pc_exec = is_b     ? pc_q + br26_off :
                   cb_taken ? pc_q + br19_off :
                              pc_q + 64'd4;

  always_comb begin
    logic [4:0]  da, sa, sb, fs;
    logic        mem_write, b_sel, en_mem, en_alu, reg_write;
    logic [63:0] imm;
    da = ZR; sa = 5'd0; sb = 5'd0; fs = FS_AND;
    mem_write = 1'b0; b_sel = 1'b0; en_mem = 1'b0; en_alu = 1'b0; reg_write = 1'b0;
    imm = 64'd0;
    if (is_rtype) begin
      da = rd; sa = rn; sb = rm; en_alu = 1'b1; reg_write = 1'b1;
      fs = is_add ? FS_ADD : is_sub ? FS_SUB : is_and ? FS_AND : is_orr ? FS_ORR : FS_EOR;
    end else if (is_itype) begin
      da = rd; sa = rn; sb = ZR; b_sel = 1'b1; en_alu = 1'b1; reg_write = 1'b1;
      imm = imm12_ext;
      fs = is_addi ? FS_ADD : is_subi ? FS_SUB : is_andi ? FS_AND : FS_ORR;
    end else if (is_ldur) begin
      // EXEC only presents the address; the RAM word is written back in MEM.
      da = rd; sa = rn; sb = ZR; fs = FS_ADD; b_sel = 1'b1; imm = imm9_ext;
      en_mem = (state_q == S_MEM);
      reg_write = (state_q == S_MEM);
    end else if (is_stur) begin
      sa = rn; sb = rd; fs = FS_ADD; b_sel = 1'b1; mem_write = 1'b1; imm = imm9_ext;
    end else if (is_cbz || is_cbnz) begin
      sa = ZR; sb = rd; fs = FS_ADD;
    end
    if (state_q == S_EXEC || state_q == S_MEM) begin
      control_word = {da, sa, sb, fs, mem_write, b_sel, en_mem, en_alu, reg_write};
      constant     = imm;
    end else begin
      control_word = NOP_WORD;
      constant     = 64'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_known ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_ldur) begin
          state_d = S_MEM;
        end else begin
          pc_d    = pc_exec;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        pc_d    = pc_q + 64'd4;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  assign instr_req = (state_q == S_FETCH) && !reset;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign state     = state_q;

endmodule
